// File: rtl/fp_mult_arbiter.sv
// Two-requester round-robin front end for a single combinational IEEE 754
// single-precision multiplier, with a registered valid/ready response port.

module fp_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product
);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic        norm, guard, sticky, rnd;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic [9:0]  exp_b;
    logic [7:0]  exp_r;
    logic [22:0] frac;

    assign ea   = a[30:23];
    assign eb   = b[30:23];
    assign fa   = a[22:0];
    assign fb   = b[22:0];
    assign sign = a[31] ^ b[31];

    // Subnormal inputs are flushed to zero.
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    assign prod   = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    assign norm   = prod[47];
    assign mant   = norm ? prod[47:24] : prod[46:23];
    assign guard  = norm ? prod[23] : prod[22];
    assign sticky = norm ? |prod[22:0] : |prod[21:0];
    assign rnd    = guard & (sticky | mant[0]);
    assign mant_r = {1'b0, mant} + {24'd0, rnd};
    assign frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    // exp_b carries the doubled bias; result exponent is exp_b - 127.
    assign exp_b  = {2'd0, ea} + {2'd0, eb} + {9'd0, norm} + {9'd0, mant_r[24]};
    assign exp_r  = exp_b[7:0] - 8'd127;

    always_comb begin
        product = {sign, exp_r, frac};
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            product = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            product = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            product = {sign, 31'd0};
        else if (exp_b >= 10'd382)
            product = {sign, 8'hFF, 23'd0};
        else if (exp_b <= 10'd127)
            product = {sign, 31'd0};
    end
endmodule

// state | meaning
// IDLE  | waiting for a request; grant and accept operands
// CALC  | operands registered, multiplier settling
// DONE  | product held on the response port until out_ready
module fp_mult_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, product;
    logic             op_id, last_id;
    logic             gnt_valid, gnt_id, accept;

    fp_multiplier u_mul (
        .a       (op_a),
        .b       (op_b),
        .product (product)
    );

    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        gnt_id    = 1'b0;
        if (req0_valid && req1_valid)
            gnt_id = ~last_id;
        else if (req1_valid)
            gnt_id = 1'b1;
    end

    // Readies are gated by rst_n so nothing looks accepted while held in reset.
    assign accept     = rst_n && (state == IDLE) && gnt_valid;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            last_id    <= 1'b1;
            out_result <= '0;
            out_id     <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (accept) begin
                op_a    <= gnt_id ? req1_a : req0_a;
                op_b    <= gnt_id ? req1_b : req0_b;
                op_id   <= gnt_id;
                last_id <= gnt_id;
            end
            if (state == CALC) begin
                out_result <= product;
                out_id     <= op_id;
            end
            if (state == DONE && out_ready)
                done_cnt <= done_cnt + 1'b1;
        end
    end
endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Sequencing and arbitration controller that shares one combinational `fp_multiplier` (IEEE 754 single precision) between two requesters. It registers the operands, lets the multiplier settle for one cycle, and registers the product. It then presents the product on a valid/ready response port tagged with the requester id. Requesters are served round-robin; completed operations are counted.

## Interface
- `WIDTH`, 32: operand/result width (IEEE 754 single; only 32 is supported).
- `CNT_W`, 16: width of the completed-operation counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_ready`  out  1  requester 0 operands accepted this edge if valid.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `out_valid`  out  1  product available.
- `out_result`  out  WIDTH  registered product `a*b`.
- `out_id`  out  1  requester that issued the product.
- `out_ready`  in  1  consumer accepts the product.
- `busy`  out  1  high whenever state is not IDLE.
- `done_cnt`  out  CNT_W  number of responses transferred; wraps modulo 2^CNT_W.

## Operation
- The block instantiates one `fp_multiplier(op_a, op_b, product)`. Its inputs are driven only from the internal operand registers.
- The state machine is IDLE → CALC → DONE → IDLE.
- **IDLE:**
  - Grant logic:
    - Neither requester valid: no grant.
    - Exactly one requester valid: that requester is granted.
    - Both valid: grant `~last_id`.
  - `reqN_ready = (state==IDLE) && grant==N`. It may depend combinationally on valid. Both readies are 0 when no requester is valid.
  - On `valid && ready`, latch a, b and the id into `op_a`, `op_b`, `op_id`; set `last_id` to the id; go to CALC.
- **CALC:**
  - One cycle, no handshakes.
  - At the next edge: `out_result <= product`, `out_id <= op_id`; go to DONE.
- **DONE:**
  - `out_valid = 1`. `out_result` and `out_id` are held stable.
  - On `out_ready`: `done_cnt <= done_cnt + 1` (wrapping); go to IDLE.
- **Requester rules:**
  - A requester must hold valid and operands stable until accepted.
  - Deasserting valid before acceptance withdraws the request, with no side effects.
- `out_valid` never drops without a transfer, except on reset.
- No operand validation is done; special values propagate per `fp_multiplier` (for example, 0 × 0 = 0x00000000).

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` falling, regardless of clock):
  - state = IDLE.
  - `out_valid`, `out_result`, `out_id`, `done_cnt`, `busy` all 0.
  - `op_a`, `op_b`, `op_id` all 0.
  - `last_id = 1`, so requester 0 wins the first contested grant.
- **Reset mid-operation:** an operation in CALC or DONE is discarded with no response and no count increment. The first grant after reset follows the rule above.
- **Latency:**
  - Accept at edge E.
  - Product registered and `out_valid` high after edge E+1.
  - Transfer at the first edge ≥ E+2 with `out_ready` high.
  - Next accept at the earliest one edge after the transfer.
- **Throughput:** peak is one operation per 3 cycles with `out_ready` held high.
- **Backpressure:** while in DONE with `out_ready` low, both readies are 0 and no new operation is accepted.
- **Round-robin:** both requesters held valid continuously are served strictly alternately, 0,1,0,1,…; neither starves.
- **Simultaneous events:**
  - A newly asserted valid arriving while in DONE is not accepted, even on the transfer edge.
  - It is granted in the following IDLE cycle.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with both valids high → all outputs 0, both readies 0; after release, req0 is granted first.
- **Single request:** req0 a=0xBF800000, b=0x3FC00000, `out_ready=1` → accepted at edge E; `out_valid` after E+1 with `out_result=0xBFC00000`, `out_id=0`; `done_cnt=1` after E+2; `busy` low after E+2.
- **Contention:** req0 0x3F800000×0x40000000, req1 0xBF800000×0xBF800000, both held valid → responses (id0, 0x40000000) then (id1, 0x3F800000), 3 cycles apart. Refilling both requesters continues the alternation 0,1,0,1.
- **Backpressure:** `out_ready=0` for 5 cycles in DONE with 0x3E4CCCCD×0x3F800000 → `out_valid=1` and `out_result=0x3E4CCCCD` stable, req readies 0, `done_cnt` unchanged; release → one transfer, count +1.
- **Asynchronous reset in CALC:** drop `rst_n` mid-cycle → `out_valid=0` and `busy=0` without a clock edge; no response for the discarded operation; 0×0 afterwards returns 0x00000000 with id 0.
- **Counter wrap:** `CNT_W=2`, 5 completed transfers → `done_cnt` sequence 1,2,3,0,1.
